// File: rtl/skinny_sbox_serial_layer.sv
// Nibble-serial SubCells controller for a 2-share SKINNY-64 state: streams each
// share's nibbles through an external masked S-box gadget and reassembles the result.
module skinny_sbox_serial_layer #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_in0,
  input  logic [4*NIBBLES-1:0] state_in1,
  input  logic [7:0]           rnd_in,
  output logic                 rnd_req,
  output logic [3:0]           sbox_in0,
  output logic [3:0]           sbox_in1,
  output logic [7:0]           sbox_ran,
  input  logic [3:0]           sbox_out0,
  input  logic [3:0]           sbox_out1,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] state_out0,
  output logic [4*NIBBLES-1:0] state_out1
);

  localparam int STATE_W = 4 * NIBBLES;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     feed_cnt_q, feed_cnt_d;
  logic [STATE_W-1:0]   buf0_q, buf1_q;
  logic [STATE_W-1:0]   out0_q, out1_q;
  logic [SBOX_LAT-1:0]  tok_vld_q;
  logic [CNT_W-1:0]     tok_idx_q [SBOX_LAT];

  logic                 feeding;
  logic                 accept;
  logic                 cap_vld;
  logic                 cap_last;
  logic [CNT_W-1:0]     cap_idx;

  // Each share is selected from its own buffer; the two are never mixed here.
  function automatic logic [3:0] nib_sel(input logic [STATE_W-1:0] v,
                                         input logic [CNT_W-1:0]   idx);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == CNT_W'(i)) r = v[4*i +: 4];
    end
    return r;
  endfunction

  assign feeding  = (state_q == S_FEED);
  assign accept   = (state_q == S_IDLE) && start;
  assign cap_vld  = tok_vld_q[SBOX_LAT-1];
  assign cap_idx  = tok_idx_q[SBOX_LAT-1];
  assign cap_last = cap_vld && (cap_idx == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FEED;
          feed_cnt_d = '0;
        end
      end
      S_FEED: begin
        if (feed_cnt_q == LAST_IDX) state_d = S_DRAIN;
        else                        feed_cnt_d = feed_cnt_q + CNT_W'(1);
      end
      S_DRAIN: begin
        if (cap_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Gadget inputs are driven only while feeding so no share or mask lingers on them.
  always_comb begin
    sbox_in0 = '0;
    sbox_in1 = '0;
    sbox_ran = '0;
    if (feeding) begin
      sbox_in0 = nib_sel(buf0_q, feed_cnt_q);
      sbox_in1 = nib_sel(buf1_q, feed_cnt_q);
      sbox_ran = rnd_in;
    end
  end

  assign rnd_req    = feeding;
  assign busy       = feeding || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign state_out0 = out0_q;
  assign state_out1 = out1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      feed_cnt_q <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      tok_vld_q  <= '0;
      for (int i = 0; i < SBOX_LAT; i++) tok_idx_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      if (accept) begin
        buf0_q <= state_in0;
        buf1_q <= state_in1;
      end
      // Token line mirrors the gadget latency so each result lands at its own index.
      tok_vld_q[0] <= feeding;
      tok_idx_q[0] <= feed_cnt_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tok_vld_q[i] <= tok_vld_q[i-1];
        tok_idx_q[i] <= tok_idx_q[i-1];
      end
      if (cap_vld) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (cap_idx == CNT_W'(i)) begin
            out0_q[4*i +: 4] <= sbox_out0;
            out1_q[4*i +: 4] <= sbox_out1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_skinny_sbox_serial_layer.sv
// Bench for skinny_sbox_serial_layer: behavioural 1-cycle masked gadget, a result
// scoreboard checked on done, and per-cycle protocol checks on the gadget interface.
`timescale 1ns/1ps
module tb_skinny_sbox_serial_layer;

  localparam int LAT = 18;
  localparam logic [63:0] VEC_IN  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VEC_OUT = 64'hC690_1A2B_385D_4E7F;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] state_in0, state_in1, state_out0, state_out1;
  logic [7:0]  rnd_in, sbox_ran;
  logic        rnd_req, busy, done;
  logic [3:0]  sbox_in0, sbox_in1, sbox_out0, sbox_out1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;
  exp_t sb[$];

  skinny_sbox_serial_layer #(.NIBBLES(16), .SBOX_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_in0(state_in0), .state_in1(state_in1), .rnd_in(rnd_in),
    .rnd_req(rnd_req), .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_ran(sbox_ran),
    .sbox_out0(sbox_out0), .sbox_out1(sbox_out1), .busy(busy), .done(done),
    .state_out0(state_out0), .state_out1(state_out1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hF7E4_D583_B2A1_096C;
    return t[4*x +: 4];
  endfunction

  // Gadget model: share1 = fresh mask, share0 = S(x) ^ mask, one register stage.
  logic [3:0] g0_q = 4'h0, g1_q = 4'h0;
  always @(posedge clk) begin
    g0_q <= sb4(sbox_in0 ^ sbox_in1) ^ sbox_ran[3:0] ^ sbox_in1;
    g1_q <= sbox_ran[3:0] ^ sbox_in1;
  end
  assign sbox_out0 = g0_q;
  assign sbox_out1 = g1_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending layer (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", state_out0 ^ state_out1, e.exp);
        chk("latency", 64'(cyc - e.acc), 64'(LAT));
      end
    end
    if (rnd_req !== 1'b1) chk("idle_gadget_inputs", {52'd0, sbox_in0, sbox_in1, sbox_ran}, 64'd0);
    else                  chk("sbox_ran", 64'(sbox_ran), 64'(rnd_in));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input logic [63:0] s0, input logic [63:0] s1,
                           input logic [63:0] exp, input bit poke,
                           input bit stab, input logic [63:0] prev);
    exp_t e;
    step();
    start     = 1'b1;
    state_in0 = s0;
    state_in1 = s1;
    rnd_in    = 8'($urandom);
    e.exp = exp;
    e.acc = cyc;
    sb.push_back(e);
    for (int k = 1; k <= LAT; k++) begin
      step();
      start  = poke && (k == 5 || k == 18);
      rnd_in = 8'($urandom);
      if (poke) begin
        state_in0 = {$urandom, $urandom};
        state_in1 = {$urandom, $urandom};
      end
      @(negedge clk);
      chk("rnd_req", 64'(rnd_req), 64'(k <= 16));
      chk("busy", 64'(busy), 64'(k <= 17));
      chk("done", 64'(done), 64'(k == 18));
      if (k <= 16) begin
        chk("sbox_in0_nibble", 64'(sbox_in0), 64'(s0[4*(k-1) +: 4]));
        chk("sbox_in1_nibble", 64'(sbox_in1), 64'(s1[4*(k-1) +: 4]));
      end
      if (stab && k <= 2) chk("hold_prev", state_out0 ^ state_out1, prev);
      if (stab && k == 3) chk("nib0_overwrite", state_out0 ^ state_out1, {prev[63:4], exp[3:0]});
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: got no finish required finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r, first0;
    bit          varied;

    // Reset with start held high
    rst = 1'b1; start = 1'b1; rnd_in = 8'hA5;
    state_in0 = 64'hDEAD_BEEF_0BAD_F00D; state_in1 = 64'h1234_5678_9ABC_DEF0;
    step(); step();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rnd_req", 64'(rnd_req), 64'd0);
    chk("rst_out0", state_out0, 64'd0);
    chk("rst_out1", state_out1, 64'd0);
    step();
    rst = 1'b0; start = 1'b0;
    step();
    @(negedge clk);
    chk("start_in_rst_ignored", 64'(busy), 64'd0);

    // Unmasked zero
    run_layer(64'd0, 64'd0, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0, 1'b0, 64'd0);
    step(); step();

    // Fixed masked split of the reference vector
    r = 64'h5A3C_96F0_1E2D_7B48;
    run_layer(VEC_IN ^ r, r, VEC_OUT, 1'b0, 1'b0, 64'd0);

    // Back-to-back layers with hold-then-overwrite of the first result
    r = {$urandom, $urandom};
    run_layer(64'hFFFF_FFFF_FFFF_FFFF ^ r, r, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0);
    r = {$urandom, $urandom};
    run_layer(64'h8888_8888_8888_8888 ^ r, r, 64'h3333_3333_3333_3333, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF);

    // start pulsed while busy and in DONE
    r = {$urandom, $urandom};
    run_layer(VEC_IN ^ r, r, VEC_OUT, 1'b1, 1'b0, 64'd0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    chk("idle_rnd_req", 64'(rnd_req), 64'd0);

    // Abort with rst in cycle 9
    step();
    r = {$urandom, $urandom};
    start = 1'b1; state_in0 = VEC_IN ^ r; state_in1 = r;
    for (int k = 1; k <= 9; k++) begin
      step();
      start  = 1'b0;
      rnd_in = 8'($urandom);
      if (k == 9) rst = 1'b1;
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rnd_req", 64'(rnd_req), 64'd0);
    chk("abort_out0", state_out0, 64'd0);
    chk("abort_out1", state_out1, 64'd0);
    step();
    @(negedge clk);
    chk("abort_token_dropped", state_out0 | state_out1, 64'd0);
    chk("abort_still_idle", 64'(busy), 64'd0);
    r = {$urandom, $urandom};
    run_layer(VEC_IN ^ r, r, VEC_OUT, 1'b0, 1'b0, 64'd0);

    // Random masks: recombined result fixed, share 0 alone must vary
    varied = 1'b0;
    first0 = '0;
    for (int n = 0; n < 1000; n++) begin
      r = {$urandom, $urandom};
      run_layer(VEC_IN ^ r, r, VEC_OUT, 1'b0, 1'b0, 64'd0);
      if (n == 0) first0 = state_out0;
      else if (state_out0 !== first0) varied = 1'b1;
    end
    chk("share0_nonconstant", 64'(varied), 64'd1);

    step(); step(); step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
